// File: rtl/apu_req_queue_pkg.sv
// Shared accelerator request types for the APU request queue.
package apu_req_queue_pkg;

  localparam int unsigned APU_REQ_W = 117;

  typedef struct packed {
    logic [2:0][31:0] operands;
    logic [5:0]       op;
    logic [14:0]      flags;
  } apu_req_t;

endpackage

// File: rtl/apu_req_fifo.sv
// Request storage for apu_req_queue: circular buffer with read/write pointers and occupancy count.
module apu_req_fifo
  import apu_req_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic                     push,
  input  logic [APU_REQ_W-1:0]     wdata,
  input  logic                     pop,
  output logic [APU_REQ_W-1:0]     rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  logic [APU_REQ_W-1:0] mem [DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic                 push_ok;
  logic                 pop_ok;

  assign full    = (count == FULL_CNT);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & (count != '0);
  assign rdata   = mem[rd_ptr];

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/apu_req_queue.sv
// APU request queue between CPU and accelerator, with response register and error flag.
// Optional empty-queue bypass enabled by defining APU_REQ_QUEUE_BYPASS_EN.
module apu_req_queue
  import apu_req_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   n_reset,
  input  logic                   core_req_i,
  output logic                   core_gnt_o,
  input  logic [2:0][31:0]       core_operands_i,
  input  logic [5:0]             core_op_i,
  input  logic [14:0]            core_flags_i,
  output logic                   core_rvalid_o,
  output logic [31:0]            core_result_o,
  output logic                   acc_req_o,
  input  logic                   acc_gnt_i,
  output logic [2:0][31:0]       acc_operands_o,
  output logic [5:0]             acc_op_o,
  output logic [14:0]            acc_flags_o,
  input  logic                   acc_rvalid_i,
  input  logic [31:0]            acc_result_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   err_o
);

  localparam int unsigned OW = $clog2(DEPTH) + 2;

  apu_req_t             core_req_s;
  apu_req_t             head_req;
  apu_req_t             acc_req_s;
  logic [APU_REQ_W-1:0] head_bits;
  logic                 full;
  logic                 bypass;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 req_taken;
  logic                 accept_rsp;
  logic [OW-1:0]        outstanding;

  assign core_req_s = '{operands: core_operands_i, op: core_op_i, flags: core_flags_i};
  assign head_req   = head_bits;

  apu_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .n_reset (n_reset),
    .push    (fifo_push),
    .wdata   (core_req_s),
    .pop     (fifo_pop),
    .rdata   (head_bits),
    .count   (count_o),
    .full    (full)
  );

  always_comb begin
    bypass = 1'b0;
`ifdef APU_REQ_QUEUE_BYPASS_EN
    // Gated by n_reset so acc_req_o stays low while reset is held.
    bypass = n_reset & (count_o == '0) & core_req_i & acc_gnt_i;
`endif
    // Full is judged on the registered count, so a same-cycle pop never frees a slot.
    core_gnt_o = core_req_i & ~full;
    acc_req_o  = (count_o != '0) | bypass;
    acc_req_s  = bypass ? core_req_s : head_req;
    fifo_push  = core_gnt_o & ~bypass;
    fifo_pop   = acc_req_o & acc_gnt_i & ~bypass;
  end

  assign acc_operands_o = acc_req_s.operands;
  assign acc_op_o       = acc_req_s.op;
  assign acc_flags_o    = acc_req_s.flags;

  assign req_taken  = core_req_i & core_gnt_o;
  assign accept_rsp = acc_rvalid_i & (outstanding != '0);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      outstanding   <= '0;
      core_rvalid_o <= 1'b0;
      core_result_o <= '0;
      err_o         <= 1'b0;
    end else begin
      case ({req_taken, accept_rsp})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      core_rvalid_o <= accept_rsp;
      if (accept_rsp)                 core_result_o <= acc_result_i;
      if (acc_rvalid_i && !accept_rsp) err_o        <= 1'b1;
    end
  end

endmodule
